// File: rtl/upsample_layer.sv
// -----------------------------------------------------------------------------
// upsample_layer
//   Expands a small signed 8-bit feature map to twice its width and height.
//   Each input pixel becomes a 2x2 block. In nearest mode the block repeats
//   the pixel. In zero-insert mode only the top-left position of the block
//   carries the pixel and the other three positions are zero.
//   Pixels leave in raster order on a valid/ready stream. Each accepted pixel
//   is also written into a parallel output map.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin one frame (sampled only in IDLE or DONE)
//   mode       0 = nearest, 1 = zero-insert (captured with input_fm in LATCH)
//   input_fm   signed input pixels, index = row*fm_in_width + col
//   out_ready  downstream accepts out_data this cycle
//   out_valid  out_data/out_index carry a valid pixel
//   out_data   signed output pixel
//   out_index  raster index of out_data, row*(2*fm_in_width) + col
//   output_fm  signed output map, index = row*(2*fm_in_width) + col
//   busy       high in LATCH and EMIT
//   done       high in DONE, held until the next start or reset
//
// Stream handshake: a pixel moves when out_valid and out_ready are both high
// at a rising edge. While out_valid is high and out_ready is low, out_data and
// out_index hold and nothing else advances. out_ready has no effect while
// out_valid is low.
// -----------------------------------------------------------------------------
module upsample_layer #(
   parameter int fm_in_width  = 3,
   parameter int fm_in_height = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   input  logic signed [7:0]      input_fm [fm_in_width*fm_in_height],
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic signed [7:0]      out_data,
   output logic [$clog2(4*fm_in_width*fm_in_height)-1:0] out_index,
   output logic signed [7:0]      output_fm [4*fm_in_width*fm_in_height],
   output logic                   busy,
   output logic                   done
);

   localparam int IN_N  = fm_in_width * fm_in_height;
   localparam int OUT_W = 2 * fm_in_width;
   localparam int OUT_H = 2 * fm_in_height;
   localparam int OUT_N = OUT_W * OUT_H;
   localparam int IDX_W = $clog2(OUT_N);
   localparam int BI_W  = $clog2(IN_N);
   localparam int RC_W  = $clog2((OUT_W > OUT_H) ? OUT_W : OUT_H);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_EMIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic signed [7:0]      buf_q [IN_N];
   logic signed [7:0]      buf_d [IN_N];
   logic                   mode_q, mode_d;
   logic [RC_W-1:0]        row_q, row_d;
   logic [RC_W-1:0]        col_q, col_d;
   logic                   out_valid_q, out_valid_d;
   logic signed [7:0]      out_data_q, out_data_d;
   logic [IDX_W-1:0]       out_index_q, out_index_d;
   logic signed [7:0]      fm_q [OUT_N];
   logic signed [7:0]      fm_d [OUT_N];

   // Raster position of an output pixel.
   function automatic logic [IDX_W-1:0] raster_idx(input logic [RC_W-1:0] r,
                                                   input logic [RC_W-1:0] c);
      return IDX_W'(r) * IDX_W'(OUT_W) + IDX_W'(c);
   endfunction

   // Source pixel in the frame buffer for an output position.
   function automatic logic [BI_W-1:0] buf_idx(input logic [RC_W-1:0] r,
                                               input logic [RC_W-1:0] c);
      return BI_W'(r >> 1) * BI_W'(fm_in_width) + BI_W'(c >> 1);
   endfunction

   // The pixel at the current counters, and at the position after them.
   logic [RC_W-1:0]   nxt_row, nxt_col;
   logic              last_px;
   logic signed [7:0] cur_pix, nxt_pix;

   always_comb begin
      last_px = (row_q == RC_W'(OUT_H - 1)) && (col_q == RC_W'(OUT_W - 1));
      if (col_q == RC_W'(OUT_W - 1)) begin
         nxt_col = '0;
         nxt_row = row_q + RC_W'(1);
      end else begin
         nxt_col = col_q + RC_W'(1);
         nxt_row = row_q;
      end
      // Zero-insert keeps only the even/even corner of each 2x2 block.
      cur_pix = (mode_q && (row_q[0] || col_q[0])) ? 8'sd0 : buf_q[buf_idx(row_q, col_q)];
      nxt_pix = (mode_q && (nxt_row[0] || nxt_col[0])) ? 8'sd0 : buf_q[buf_idx(nxt_row, nxt_col)];
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      mode_d      = mode_q;
      row_d       = row_q;
      col_d       = col_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      fm_d        = fm_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LATCH;
         end

         S_LATCH: begin
            buf_d   = input_fm;
            mode_d  = mode;
            row_d   = '0;
            col_d   = '0;
            state_d = S_EMIT;
         end

         S_EMIT: begin
            if (!out_valid_q) begin
               // First EMIT cycle: present pixel (0,0) from the fresh buffer.
               out_valid_d = 1'b1;
               out_data_d  = cur_pix;
               out_index_d = raster_idx(row_q, col_q);
            end else if (out_ready) begin
               fm_d[out_index_q] = out_data_q;
               if (last_px) begin
                  out_valid_d = 1'b0;
                  out_data_d  = 8'sd0;
                  state_d     = S_DONE;
               end else begin
                  row_d       = nxt_row;
                  col_d       = nxt_col;
                  out_data_d  = nxt_pix;
                  out_index_d = raster_idx(nxt_row, nxt_col);
               end
            end
         end

         S_DONE: begin
            if (start) state_d = S_LATCH;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'sd0;
         out_index_q <= '0;
         for (int i = 0; i < IN_N; i++)  buf_q[i] <= 8'sd0;
         for (int i = 0; i < OUT_N; i++) fm_q[i]  <= 8'sd0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         buf_q       <= buf_d;
         fm_q        <= fm_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign output_fm = fm_q;
   assign busy      = (state_q == S_LATCH) || (state_q == S_EMIT);
   assign done      = (state_q == S_DONE);

endmodule
